gray_counter_ud: RTL and testbench

Parametrised up/down Gray-code counter with count enable, synchronous parallel load, and an overflow pulse. It replaces the fixed free-running Gray sequence generator wherever a pointer or position needs to be stepped, reversed, or preset. Typical users are async-FIFO pointers, rotary/position trackers, and low-toggle sequence generators. Internally it keeps a binary count; `out` is the standard reflected Gray encoding of that count.

---
 rtl/gray_pkg.sv | 13 +
 rtl/gray_to_bin.sv | 17 +
 rtl/gray_counter_ud.sv | 89 ++++++++
 tb/tb_gray_counter_ud.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared types and limits for the Gray-code counter family.
//   gray_dir_t      - step direction, DIR_DOWN (0) / DIR_UP (1)
//   GRAY_MAX_WIDTH  - widest counter the family supports
package gray_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } gray_dir_t;

    localparam int GRAY_MAX_WIDTH = 32;

endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin: purely combinational reflected-Gray to binary converter.
//   WIDTH  - word width
//   gray   in  Gray-coded word
//   bin    out binary equivalent
module gray_to_bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at and above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_counter_ud.sv
// gray_counter_ud: up/down Gray-code counter with enable, synchronous Gray-coded
// load and a one-cycle boundary (overflow/underflow) pulse.
//   clk       in  clock, rising edge
//   reset     in  synchronous active-high reset
//   en        in  count enable
//   up        in  direction, 1 = increment, 0 = decrement
//   load      in  synchronous load of load_val (beats en)
//   load_val  in  Gray-coded preset
//   out       out registered Gray count
//   bin_out   out registered binary count
//   ovf       out registered pulse on a boundary step
// Build option: define GRAY_COUNTER_UD_SAT_EN to saturate at the boundaries
// instead of wrapping; ovf still pulses on every boundary step.
module gray_counter_ud
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] bin_out,
    output logic             ovf
);

    if (int'(WIDTH) < 2 || int'(WIDTH) > GRAY_MAX_WIDTH) begin : g_width_check
        $error("gray_counter_ud: WIDTH must be in 2..%0d", GRAY_MAX_WIDTH);
    end

    localparam logic [WIDTH-1:0] CntMax = '1;
    localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] load_bin;
    logic             ovf_d;
    logic             boundary;
    gray_dir_t        dir;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_load_conv (
        .gray (load_val),
        .bin  (load_bin)
    );

    assign dir = gray_dir_t'(up);

    // A step that would leave the representable range in the chosen direction.
    assign boundary = en && !load &&
                      (((dir == DIR_UP) && (cnt_q == CntMax)) ||
                       ((dir == DIR_DOWN) && (cnt_q == '0)));

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (load) begin
            cnt_d = load_bin;
        end else if (en) begin
            ovf_d = boundary;
`ifdef GRAY_COUNTER_UD_SAT_EN
            if (!boundary) begin
                cnt_d = (dir == DIR_UP) ? cnt_q + CntOne : cnt_q - CntOne;
            end
`else
            // Modulo arithmetic gives the wrap for free.
            cnt_d = (dir == DIR_UP) ? cnt_q + CntOne : cnt_q - CntOne;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            out   <= '0;
            ovf   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out   <= cnt_d ^ (cnt_d >> 1);
            ovf   <= ovf_d;
        end
    end

    assign bin_out = cnt_q;

endmodule

// File: tb/tb_gray_counter_ud.sv
// Scoreboard bench for gray_counter_ud (WIDTH=4). The driver applies one
// vector per cycle on the falling edge and queues the hand-computed response;
// the monitor checks one queued response shortly after each rising edge.
module tb_gray_counter_ud;

    typedef struct {
        logic [3:0] gout;
        logic [3:0] bin;
        logic       ovf;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'h0;
    logic [3:0] out;
    logic [3:0] bin_out;
    logic       ovf;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    gray_counter_ud #(
        .WIDTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .bin_out  (bin_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic l, input logic e, input logic u,
                         input logic [3:0] lv, input logic [3:0] eg, input logic [3:0] eb,
                         input logic eo, input string nm);
        exp_t x;
        @(negedge clk);
        reset    = r;
        load     = l;
        en       = e;
        up       = u;
        load_val = lv;
        x.gout   = eg;
        x.bin    = eb;
        x.ovf    = eo;
        x.name   = nm;
        exp_q.push_back(x);
    endtask

    // Monitor: the DUT presents a new response after every rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (out !== x.gout || bin_out !== x.bin || ovf !== x.ovf) begin
                    errors++;
                    $display("FAIL %s: got out=%h bin_out=%h ovf=%b, want out=%h bin_out=%h ovf=%b",
                             x.name, out, bin_out, ovf, x.gout, x.bin, x.ovf);
                end
            end
        end
    end

    initial begin
        logic [3:0] gseq [17];
        logic [3:0] bseq [17];
        logic       oseq [17];
        int         wait_cycles;

        // Wrap-mode up sequence from 0: gray / binary / ovf after each step.
        gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD,
                 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1};
        bseq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
        oseq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
`ifdef GRAY_COUNTER_UD_SAT_EN
        // Saturates at binary F (gray 8); every further up-step pulses ovf.
        gseq[15] = 4'h8; bseq[15] = 4'hF; oseq[15] = 1'b1;
        gseq[16] = 4'h8; bseq[16] = 4'hF; oseq[16] = 1'b1;
`endif

        // 1: reset held with en high, outputs stay zero.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 1, 4'h0, 4'h0, 4'h0, 0, $sformatf("reset_hold%0d", i));
        end

        // 2: seventeen up-steps from 0, including the wrap / saturation.
        for (int i = 0; i < 17; i++) begin
            drive(0, 0, 1, 1, 4'h0, gseq[i], bseq[i], oseq[i], $sformatf("up_step%0d", i + 1));
        end

        // 3: reset, then two down-steps from 0.
        drive(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, "reset_before_down");
`ifdef GRAY_COUNTER_UD_SAT_EN
        drive(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 1, "down_from_zero");
        drive(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 1, "down_again");
`else
        drive(0, 0, 1, 0, 4'h0, 4'h8, 4'hF, 1, "down_from_zero");
        drive(0, 0, 1, 0, 4'h0, 4'h9, 4'hE, 0, "down_again");
`endif

        // 4: load beats en; then one step each way.
        drive(0, 1, 1, 1, 4'hC, 4'hC, 4'h8, 0, "load_c_with_en");
        drive(0, 0, 1, 1, 4'h0, 4'hD, 4'h9, 0, "up_after_load");
        drive(0, 0, 1, 0, 4'h0, 4'hC, 4'h8, 0, "down_after_up");

        // 5: hold at gray 6 while up toggles.
        drive(0, 1, 0, 0, 4'h6, 4'h6, 4'h4, 0, "load_6");
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, i[0], 4'h0, 4'h6, 4'h4, 0, $sformatf("hold%0d", i));
        end

        // Load at the top boundary, then back-to-back boundary steps.
        drive(0, 1, 0, 0, 4'h8, 4'h8, 4'hF, 0, "load_max");
`ifdef GRAY_COUNTER_UD_SAT_EN
        drive(0, 0, 1, 1, 4'h0, 4'h8, 4'hF, 1, "up_at_max");
        drive(0, 0, 1, 0, 4'h0, 4'h9, 4'hE, 0, "down_from_max");
`else
        drive(0, 0, 1, 1, 4'h0, 4'h0, 4'h0, 1, "up_at_max");
        drive(0, 0, 1, 0, 4'h0, 4'h8, 4'hF, 1, "down_from_zero_b2b");
`endif
        drive(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0, "load_zero_with_en");

        // 6: reset overrides a concurrent load; counting restarts at 0.
        drive(0, 1, 0, 0, 4'hE, 4'hE, 4'hB, 0, "load_e");
        drive(1, 1, 1, 1, 4'h3, 4'h0, 4'h0, 0, "reset_over_load");
        drive(0, 0, 1, 1, 4'h0, 4'h1, 4'h1, 0, "restart_step1");
        drive(0, 0, 1, 1, 4'h0, 4'h3, 4'h2, 0, "restart_step2");
        drive(0, 0, 0, 1, 4'h0, 4'h3, 4'h2, 0, "idle_after_restart");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
